// File: rtl/int_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg
// Shared definitions for the interrupt controller:
//   state_e   - controller FSM states
//   CSR_*     - register-port addresses
//   vec_addr  - vector address of an interrupt index
// -----------------------------------------------------------------------------
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] CSR_IE   = 2'd0;
    localparam logic [1:0] CSR_PEND = 2'd1;
    localparam logic [1:0] CSR_GIE  = 2'd2;
    localparam logic [1:0] CSR_STAT = 2'd3;

    // Vector of interrupt idx: base + (idx << shift).
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int          shift,
                                             input logic [3:0]  idx);
        return base + ({12'd0, idx} << shift);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   req_i   [W-1:0] request vector, bit 0 is highest priority
//   valid_o         at least one request bit set
//   idx_o   [3:0]   index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module int_prio_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid_o = |req_i;
        idx_o   = 4'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller for the program counter's interrupt-jump path.
// Latches rising edges on the request lines, masks them with IE, picks the
// lowest eligible index, and at an instruction boundary issues a one-cycle
// INTjmp pulse with the vector on Aint. Tracks in-service state until RetI.
//
// Build option:
//   INT_NEST_EN  defined   - nested service; a higher-priority eligible
//                            request preempts the one in service, and RetI
//                            retires the highest-priority in-service level.
//                undefined - single level; no takes while in service, RetI
//                            always returns to idle.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   IRQ[N_IRQ]      edge-sensitive request lines
//   Boundary        control unit may be redirected this cycle
//   RetI            return-from-interrupt strobe
//   CsrWe/CsrAddr/CsrDin/CsrDout   register port (read is combinational)
//       0 IE (R/W), 1 pending (R, W1C), 2 GIE bit 0 (R/W),
//       3 status {InService, 3'b0, Cause, in-service vector [7:0]}
//   INTjmp          one-cycle take pulse
//   Aint            vector address, held between takes
//   InService       any interrupt in service
//   Cause           index of the most recently taken interrupt
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int          N_IRQ     = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0100,
    parameter int          VEC_SHIFT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             Boundary,
    input  logic             RetI,
    input  logic             CsrWe,
    input  logic [1:0]       CsrAddr,
    input  logic [15:0]      CsrDin,
    output logic [15:0]      CsrDout,
    output logic             INTjmp,
    output logic [15:0]      Aint,
    output logic             InService,
    output logic [3:0]       Cause
);

    import int_pkg::*;

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] ie_q, ie_d;
    logic [N_IRQ-1:0] insvc_q, insvc_d;
    logic             gie_q, gie_d;
    logic [3:0]       cause_q, cause_d;
    logic [15:0]      aint_q, aint_d;

    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] take_mask;
    logic [N_IRQ-1:0] retire_mask;
    logic [N_IRQ-1:0] csr_clr;
    logic             elig_valid;
    logic [3:0]       sel;
    logic             svc_valid;
    logic [3:0]       svc_idx;
    logic             take;

    assign irq_rise = IRQ & ~prev_q;
    assign eligible = pend_q & ie_q;

    int_prio_enc #(.W(N_IRQ)) u_sel_enc (
        .req_i   (eligible),
        .valid_o (elig_valid),
        .idx_o   (sel)
    );

    // Highest-priority level currently in service; drives preemption
    // compare and which level RetI retires.
    int_prio_enc #(.W(N_IRQ)) u_svc_enc (
        .req_i   (insvc_q),
        .valid_o (svc_valid),
        .idx_o   (svc_idx)
    );

    assign take_mask   = N_IRQ'(1) << sel;
    assign retire_mask = N_IRQ'(1) << svc_idx;

    always_comb begin
        state_d = state_q;
        insvc_d = insvc_q;
        cause_d = cause_q;
        aint_d  = aint_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gie_q && Boundary && elig_valid) begin
                    take = 1'b1;
                end
            end
            TAKE: begin
                // RetI is ignored here; the jump cycle always completes.
                state_d = SERVICE;
            end
            SERVICE: begin
                if (RetI) begin
                    // Return wins over any take in the same cycle.
                    insvc_d = insvc_q & ~retire_mask;
`ifdef INT_NEST_EN
                    if (insvc_d == '0) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
`ifdef INT_NEST_EN
                else if (gie_q && Boundary && elig_valid && (sel < svc_idx)) begin
                    take = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d = TAKE;
            insvc_d = insvc_q | take_mask;
            cause_d = sel;
            aint_d  = vec_addr(VEC_BASE, VEC_SHIFT, sel);
        end
    end

    // A new edge on a bit being cleared the same cycle keeps it pending.
    always_comb begin
        csr_clr = '0;
        if (CsrWe && (CsrAddr == CSR_PEND)) begin
            csr_clr = CsrDin[N_IRQ-1:0];
        end
        pend_d = (pend_q & ~(take ? take_mask : '0) & ~csr_clr) | irq_rise;
    end

    always_comb begin
        ie_d  = ie_q;
        gie_d = gie_q;
        if (CsrWe && (CsrAddr == CSR_IE)) begin
            ie_d = CsrDin[N_IRQ-1:0];
        end
        if (CsrWe && (CsrAddr == CSR_GIE)) begin
            gie_d = CsrDin[0];
        end
    end

    always_comb begin
        CsrDout = '0;
        case (CsrAddr)
            CSR_IE:   CsrDout[N_IRQ-1:0] = ie_q;
            CSR_PEND: CsrDout[N_IRQ-1:0] = pend_q;
            CSR_GIE:  CsrDout[0]         = gie_q;
            CSR_STAT: CsrDout            = {svc_valid, 3'b000, cause_q, 8'(insvc_q)};
            default:  CsrDout            = '0;
        endcase
    end

    // prev resets to all-ones so lines already high at reset release are
    // not seen as edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            prev_q  <= '1;
            pend_q  <= '0;
            ie_q    <= '0;
            gie_q   <= 1'b0;
            insvc_q <= '0;
            cause_q <= 4'd0;
            aint_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            prev_q  <= IRQ;
            pend_q  <= pend_d;
            ie_q    <= ie_d;
            gie_q   <= gie_d;
            insvc_q <= insvc_d;
            cause_q <= cause_d;
            aint_q  <= aint_d;
        end
    end

    assign INTjmp    = (state_q == TAKE);
    assign Aint      = aint_q;
    assign InService = svc_valid;
    assign Cause     = cause_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  IRQ;
    logic        Boundary;
    logic        RetI;
    logic        CsrWe;
    logic [1:0]  CsrAddr;
    logic [15:0] CsrDin;
    logic [15:0] CsrDout;
    logic        INTjmp;
    logic [15:0] Aint;
    logic        InService;
    logic [3:0]  Cause;

    int total = 0;
    int bad   = 0;
    int n_jmp = 0;

    // Reference model: pending set, enables, a set of in-service levels,
    // a flag for the jump cycle, and the last taken vector/cause.
    logic [7:0]  m_prev, m_pend, m_ie, m_svc;
    logic        m_gie, m_jump;
    logic [15:0] m_aint;
    logic [3:0]  m_cause;

    always #5 CLK = ~CLK;

    int_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ       (IRQ),
        .Boundary  (Boundary),
        .RetI      (RetI),
        .CsrWe     (CsrWe),
        .CsrAddr   (CsrAddr),
        .CsrDin    (CsrDin),
        .CsrDout   (CsrDout),
        .INTjmp    (INTjmp),
        .Aint      (Aint),
        .InService (InService),
        .Cause     (Cause)
    );

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] csr_exp(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_ie};
            2'd1:    return {8'h00, m_pend};
            2'd2:    return {15'd0, m_gie};
            default: return {(m_svc != 8'h00), 3'b000, m_cause, m_svc};
        endcase
    endfunction

    task automatic model_reset();
        m_prev  = 8'hFF;
        m_pend  = 8'h00;
        m_ie    = 8'h00;
        m_svc   = 8'h00;
        m_gie   = 1'b0;
        m_jump  = 1'b0;
        m_aint  = 16'h0000;
        m_cause = 4'd0;
    endtask

    task automatic model_edge();
        logic [7:0] rise;
        int s, top;
        bit tk;
        if (RST) begin
            model_reset();
            return;
        end
        rise   = IRQ & ~m_prev;
        m_prev = IRQ;
        s      = lowest(m_pend & m_ie);
        top    = lowest(m_svc);
        tk     = 1'b0;
        if (m_jump) begin
            m_jump = 1'b0;
        end else if (m_svc == 8'h00) begin
            tk = m_gie && Boundary && (s >= 0);
        end else if (RetI) begin
`ifdef INT_NEST_EN
            m_svc[top] = 1'b0;
`else
            m_svc = 8'h00;
`endif
        end
`ifdef INT_NEST_EN
        else begin
            tk = m_gie && Boundary && (s >= 0) && (s < top);
        end
`endif
        if (tk) begin
            m_jump    = 1'b1;
            m_pend[s] = 1'b0;
            m_svc[s]  = 1'b1;
            m_cause   = s[3:0];
            m_aint    = 16'h0100 + 16'(s * 4);
        end
        if (CsrWe) begin
            case (CsrAddr)
                2'd0:    m_ie   = CsrDin[7:0];
                2'd1:    m_pend = m_pend & ~CsrDin[7:0];
                2'd2:    m_gie  = CsrDin[0];
                default: ;
            endcase
        end
        m_pend = m_pend | rise;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        if (INTjmp === 1'b1) n_jmp++;
        chk("intjmp", {15'd0, INTjmp}, {15'd0, m_jump});
        chk("aint", Aint, m_aint);
        chk("inservice", {15'd0, InService}, {15'd0, (m_svc != 8'h00)});
        chk("cause", {12'd0, Cause}, {12'd0, m_cause});
        chk("csr_dout", CsrDout, csr_exp(CsrAddr));
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [15:0] d);
        CsrWe   = 1'b1;
        CsrAddr = a;
        CsrDin  = d;
        cyc();
        CsrWe   = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        int j0;
        model_reset();
        RST = 1'b1; IRQ = 8'h01; Boundary = 1'b0; RetI = 1'b0;
        CsrWe = 1'b0; CsrAddr = 2'd0; CsrDin = 16'h0000;

        // Reset with IRQ0 held high: no edge, no take.
        cyc(); cyc();
        chk("rst_aint", Aint, 16'h0000);
        chk("rst_cause", {12'd0, Cause}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            CsrAddr = 2'(a);
            #1;
            chk("rst_csr", CsrDout, 16'h0000);
        end
        RST = 1'b0; Boundary = 1'b1;
        csr_wr(2'd0, 16'h00FF);
        csr_wr(2'd2, 16'h0001);
        repeat (8) cyc();
        chk("held_irq_no_take", 16'(n_jmp), 16'd0);

        // IRQ3 and IRQ2 together, IE=0C: IRQ2 first, then IRQ3.
        IRQ = 8'h00; Boundary = 1'b0;
        do_reset();
        csr_wr(2'd0, 16'h000C);
        csr_wr(2'd2, 16'h0001);
        IRQ = 8'h0C; Boundary = 1'b1; CsrAddr = 2'd1;
        cyc();
        chk("pend_2_3", CsrDout, 16'h000C);
        chk("no_jmp_yet", {15'd0, INTjmp}, 16'h0000);
        cyc();
        chk("take2_jmp", {15'd0, INTjmp}, 16'h0001);
        chk("take2_aint", Aint, 16'h0108);
        chk("take2_cause", {12'd0, Cause}, 16'h0002);
        chk("take2_pend", CsrDout, 16'h0008);
        cyc();
        chk("jmp_one_cycle", {15'd0, INTjmp}, 16'h0000);
        chk("in_service", {15'd0, InService}, 16'h0001);
        RetI = 1'b1; cyc(); RetI = 1'b0;
        chk("reti_idle", {15'd0, InService}, 16'h0000);
        cyc();
        chk("take3_aint", Aint, 16'h010C);
        cyc();
        RetI = 1'b1; cyc(); RetI = 1'b0;

        // Masked pending IRQ5, then enabled by IE write.
        IRQ = 8'h00;
        do_reset();
        csr_wr(2'd2, 16'h0001);
        IRQ = 8'h20; Boundary = 1'b1; CsrAddr = 2'd1;
        repeat (4) cyc();
        chk("masked_pend", CsrDout, 16'h0020);
        csr_wr(2'd0, 16'h0020);
        chk("ie_next_cycle", {15'd0, INTjmp}, 16'h0000);
        cyc();
        chk("take5_aint", Aint, 16'h0114);
        cyc();
        RetI = 1'b1; cyc(); RetI = 1'b0;

        // Masked pending IRQ5 cleared by W1C: nothing taken afterwards.
        IRQ = 8'h00;
        do_reset();
        csr_wr(2'd2, 16'h0001);
        IRQ = 8'h20;
        cyc();
        csr_wr(2'd1, 16'h0020);
        chk("w1c_pend", CsrDout, 16'h0000);
        j0 = n_jmp;
        csr_wr(2'd0, 16'h0020);
        repeat (3) cyc();
        chk("w1c_no_take", 16'(n_jmp - j0), 16'd0);

        // IRQ1 arrives while IRQ4 is in service.
        IRQ = 8'h00;
        do_reset();
        csr_wr(2'd0, 16'h0012);
        csr_wr(2'd2, 16'h0001);
        Boundary = 1'b1; IRQ = 8'h10;
        cyc(); cyc();
        chk("take4_aint", Aint, 16'h0110);
        cyc();
        IRQ = 8'h12;
        cyc();
`ifdef INT_NEST_EN
        cyc();
        chk("preempt_aint", Aint, 16'h0104);
        cyc();
        RetI = 1'b1; cyc(); RetI = 1'b0;
        chk("nest_still_busy", {15'd0, InService}, 16'h0001);
        RetI = 1'b1; cyc(); RetI = 1'b0;
        chk("nest_idle", {15'd0, InService}, 16'h0000);
`else
        j0 = n_jmp;
        repeat (3) cyc();
        chk("no_take_in_service", 16'(n_jmp - j0), 16'd0);
        RetI = 1'b1; cyc(); RetI = 1'b0;
        cyc();
        chk("after_ret_take_aint", Aint, 16'h0104);
        chk("after_ret_take_jmp", {15'd0, INTjmp}, 16'h0001);
        cyc();
        RetI = 1'b1; cyc(); RetI = 1'b0;
`endif

        // RetI and Boundary together with IRQ0 pending.
        IRQ = 8'h00; Boundary = 1'b0;
        do_reset();
        csr_wr(2'd0, 16'h0003);
        csr_wr(2'd2, 16'h0001);
        Boundary = 1'b1; IRQ = 8'h02;
        cyc(); cyc();
        chk("take1_aint", Aint, 16'h0104);
        Boundary = 1'b0;
        cyc();
        IRQ = 8'h03;
        cyc(); cyc();
        RetI = 1'b1; Boundary = 1'b1;
        cyc();
        RetI = 1'b0;
        chk("ret_first_no_jmp", {15'd0, INTjmp}, 16'h0000);
        cyc();
        chk("take0_jmp", {15'd0, INTjmp}, 16'h0001);
        chk("take0_aint", Aint, 16'h0100);

        // Reset while in service with something pending.
        IRQ = 8'h00; cyc();
        IRQ = 8'h02; cyc();
        cyc();
        RST = 1'b1; cyc(); RST = 1'b0;
        chk("rst_svc_insvc", {15'd0, InService}, 16'h0000);
        CsrAddr = 2'd1; #1;
        chk("rst_svc_pend", CsrDout, 16'h0000);
        CsrAddr = 2'd0; #1;
        chk("rst_svc_ie", CsrDout, 16'h0000);
        cyc();

        // Randomized traffic against the model.
        IRQ = 8'h00;
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        csr_wr(2'd2, 16'h0001);
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 11) == 0) IRQ[b] = ~IRQ[b];
            end
            Boundary = ($urandom_range(0, 3) != 0);
            RetI     = ($urandom_range(0, 5) == 0);
            CsrWe    = ($urandom_range(0, 9) == 0);
            CsrAddr  = 2'($urandom_range(0, 3));
            CsrDin   = 16'($urandom);
            if (CsrWe && CsrAddr == 2'd2) CsrDin[0] = ($urandom_range(0, 3) != 0);
            RST      = ($urandom_range(0, 499) == 0);
            cyc();
        end
        RST = 1'b0; CsrWe = 1'b0; RetI = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
